// File: rtl/cu_sleep_requester.sv
// Per-compute-unit end-of-kernel detector. Watches warp and pipeline activity,
// raises a one-cycle sleep request once the CU has been idle long enough, then
// holds off the controller (cu_delay_sleep_o) until the L1 flush has completed
// and all outstanding memory traffic has drained.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_ARM   | after reset, waiting for the first kernel launch (any warp active)
//   S_RUN   | kernel running, counting consecutive idle cycles
//   S_FLUSH | sleep requested (first cycle), L1 flush requested, delay held
//   S_DRAIN | flush done, waiting for outstanding memory requests to reach 0
//   S_SLEEP | delay released, terminal until the CU is reset

module cu_sleep_requester #(
   parameter int unsigned NUM_WARPS       = 4,
   parameter int unsigned IDLE_CYCLES     = 4,
   parameter int unsigned MAX_OUTSTANDING = 15,
   localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_WARPS-1:0] warp_active_i,
   input  logic                 busy_i,
   input  logic                 mem_req_fire_i,
   input  logic                 mem_rsp_fire_i,
   output logic                 flush_req_o,
   input  logic                 flush_done_i,
   output logic                 cu_sleep_req_o,
   output logic                 cu_delay_sleep_o,
   output logic [CW-1:0]        outstanding_o,
   output logic                 err_o
);

   localparam int unsigned IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] OUT_MAX   = CW'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      S_ARM   = 3'd0,
      S_RUN   = 3'd1,
      S_FLUSH = 3'd2,
      S_DRAIN = 3'd3,
      S_SLEEP = 3'd4
   } state_t;

   state_t         state_q;
   logic [IW-1:0]  idle_cnt_q;
   logic [CW-1:0]  outstanding_q;
   logic           sleep_req_q;
   logic           flush_req_q;
   logic           delay_q;
   logic           err_q;

   logic any_warp;
   logic idle;
   logic req_only;
   logic rsp_only;
   logic late_state;
   logic err_set;

   assign any_warp   = |warp_active_i;
   assign idle       = !any_warp && !busy_i;
   assign req_only   = mem_req_fire_i && !mem_rsp_fire_i;
   assign rsp_only   = mem_rsp_fire_i && !mem_req_fire_i;
   assign late_state = (state_q == S_FLUSH) || (state_q == S_DRAIN) || (state_q == S_SLEEP);

   // Protocol violations only flag the error; they never steer the FSM.
   assign err_set = (late_state && (any_warp || mem_req_fire_i))
                 || (flush_done_i && (state_q != S_FLUSH))
                 || (rsp_only && (outstanding_q == '0))
                 || (req_only && (outstanding_q == OUT_MAX));

   // Sequencing FSM; outputs are registered alongside the state so they change
   // exactly on state entry (delay rises in the same cycle as the sleep pulse).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_ARM;
         idle_cnt_q  <= '0;
         sleep_req_q <= 1'b0;
         flush_req_q <= 1'b0;
         delay_q     <= 1'b0;
      end else begin
         sleep_req_q <= 1'b0;
         unique case (state_q)
            S_ARM: begin
               if (any_warp) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (!idle) begin
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == IDLE_LAST) begin
                  idle_cnt_q  <= '0;
                  state_q     <= S_FLUSH;
                  sleep_req_q <= 1'b1;
                  flush_req_q <= 1'b1;
                  delay_q     <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + IW'(1);
               end
            end
            S_FLUSH: begin
               if (flush_done_i) begin
                  state_q     <= S_DRAIN;
                  flush_req_q <= 1'b0;
               end
            end
            S_DRAIN: begin
               if ((outstanding_q == '0) && !mem_req_fire_i && !mem_rsp_fire_i) begin
                  state_q <= S_SLEEP;
                  delay_q <= 1'b0;
               end
            end
            S_SLEEP: begin
               state_q <= S_SLEEP;
            end
            default: begin
               state_q     <= S_ARM;
               idle_cnt_q  <= '0;
               flush_req_q <= 1'b0;
               delay_q     <= 1'b0;
            end
         endcase
      end
   end

   // In-flight memory request counter; saturates at both ends instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else if (req_only && (outstanding_q != OUT_MAX)) begin
         outstanding_q <= outstanding_q + CW'(1);
      end else if (rsp_only && (outstanding_q != '0)) begin
         outstanding_q <= outstanding_q - CW'(1);
      end
   end

   // Sticky protocol error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign cu_sleep_req_o   = sleep_req_q;
   assign flush_req_o      = flush_req_q;
   assign cu_delay_sleep_o = delay_q;
   assign outstanding_o    = outstanding_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_cu_sleep_requester.sv
// Self-checking bench for cu_sleep_requester: directed scenarios plus random
// activity patterns checked against a sliding-window idle model and a
// saturating-arithmetic model of the outstanding counter.

module tb_cu_sleep_requester;

   localparam int IDLE_CYCLES = 4;
   localparam int MAX_OUT     = 15;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [3:0] warp_active;
   logic       busy;
   logic       req;
   logic       rsp;
   logic       flush_done;
   logic       flush_req_o;
   logic       cu_sleep_req_o;
   logic       cu_delay_sleep_o;
   logic [3:0] outstanding_o;
   logic       err_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0] pat_w [64];
   logic       pat_b [64];
   int         pat_len;

   cu_sleep_requester dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .warp_active_i   (warp_active),
      .busy_i          (busy),
      .mem_req_fire_i  (req),
      .mem_rsp_fire_i  (rsp),
      .flush_req_o     (flush_req_o),
      .flush_done_i    (flush_done),
      .cu_sleep_req_o  (cu_sleep_req_o),
      .cu_delay_sleep_o(cu_delay_sleep_o),
      .outstanding_o   (outstanding_o),
      .err_o           (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one cycle; outputs are observed and inputs changed 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      warp_active = '0; busy = 0; req = 0; rsp = 0; flush_done = 0;
      rst_ni = 0;
      tick();
      tick();
      rst_ni = 1;
   endtask

   task automatic test_reset();
      int pulses;
      int delays;
      warp_active = '0; busy = 0; req = 0; rsp = 0; flush_done = 0;
      rst_ni = 0;
      #3;
      n_checks++;
      if ({cu_sleep_req_o, flush_req_o, cu_delay_sleep_o, err_o, outstanding_o} !== 8'h00)
         $display("FAIL reset_outputs: got %b expected 00000000",
                  {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o, err_o, outstanding_o});
      else n_pass++;
      tick();
      rst_ni = 1;
      pulses = 0; delays = 0;
      for (int c = 0; c < 20; c++) begin
         if (cu_sleep_req_o) pulses++;
         if (cu_delay_sleep_o || flush_req_o) delays++;
         busy = 1'($urandom_range(0, 1));
         tick();
      end
      busy = 0;
      n_checks++;
      if (pulses != 0) $display("FAIL arm_no_pulse: got %0d pulses expected 0", pulses);
      else n_pass++;
      n_checks++;
      if (delays != 0) $display("FAIL arm_no_delay: got %0d cycles with flush/delay expected 0", delays);
      else n_pass++;
   endtask

   task automatic test_idle_timing();
      logic [2:0] obs;
      logic [2:0] exp_v;
      do_reset();
      warp_active = 4'b0011;
      repeat (10) tick();
      for (int n = 1; n <= 6; n++) begin
         exp_v = {(n == 5), (n >= 5), (n >= 5)};
         obs   = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
         n_checks++;
         if (obs !== exp_v)
            $display("FAIL idle_timing cycle %0d: {req,flush,delay} got %b expected %b", n, obs, exp_v);
         else n_pass++;
         warp_active = '0; busy = 0;
         tick();
      end
      flush_done = 1;
      tick();
      flush_done = 0;
      obs = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
      n_checks++;
      if (obs !== 3'b001) $display("FAIL drain_outputs: got %b expected 001", obs);
      else n_pass++;
      tick();
      obs = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
      n_checks++;
      if (obs !== 3'b000 || err_o !== 1'b0)
         $display("FAIL sleep_outputs: got %b err %b expected 000 err 0", obs, err_o);
      else n_pass++;
   endtask

   // Drives pat_w/pat_b from reset; expected pulse when the preceding
   // IDLE_CYCLES cycles (after the first warp activity) were all idle.
   task automatic run_pattern(input string name, output int fired_at);
      int         streak;
      bit         seen;
      bit         fired;
      bit         idle_c;
      logic [2:0] exp_v;
      logic [2:0] obs;
      streak = 0; seen = 0; fired = 0; fired_at = -1;
      do_reset();
      for (int n = 0; n < pat_len; n++) begin
         exp_v = 3'b000;
         if (!fired && streak >= IDLE_CYCLES) begin
            fired    = 1;
            fired_at = n;
            exp_v    = 3'b111;
         end else if (fired) begin
            exp_v = 3'b011;
         end
         obs = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
         n_checks++;
         if (obs !== exp_v)
            $display("FAIL %s cycle %0d: {req,flush,delay} got %b expected %b", name, n, obs, exp_v);
         else n_pass++;
         if (fired) begin
            warp_active = '0; busy = 0;
         end else begin
            warp_active = pat_w[n]; busy = pat_b[n];
            idle_c = (pat_w[n] == 4'b0) && !pat_b[n];
            if (seen && idle_c) streak++;
            else streak = 0;
            if (pat_w[n] != 4'b0) seen = 1;
         end
         tick();
      end
      warp_active = '0; busy = 0;
      n_checks++;
      if (err_o !== 1'b0) $display("FAIL %s err: got %b expected 0", name, err_o);
      else n_pass++;
   endtask

   task automatic test_idle_restart();
      int fired_at;
      pat_len = 16;
      for (int i = 0; i < 16; i++) begin pat_w[i] = 4'b0000; pat_b[i] = 0; end
      pat_w[0] = 4'b0001; pat_w[1] = 4'b0001;
      pat_w[5] = 4'b0100;
      run_pattern("idle_restart", fired_at);
      n_checks++;
      if (fired_at != 10) $display("FAIL idle_restart_pulse: got cycle %0d expected 10", fired_at);
      else n_pass++;
   endtask

   task automatic test_random_patterns();
      int fired_at;
      for (int t = 0; t < 8; t++) begin
         pat_len = 40;
         for (int i = 0; i < 40; i++) begin
            pat_w[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            pat_b[i] = ($urandom_range(0, 4) == 0);
         end
         run_pattern("random_pattern", fired_at);
      end
   endtask

   task automatic test_drain();
      int p, zero_at, fall_at, early_drop;
      logic [3:0] out_at_pulse;
      do_reset();
      warp_active = 4'b0001; req = 1;
      repeat (3) tick();
      warp_active = '0; req = 0;
      p = -1; zero_at = -1; fall_at = -1; early_drop = 0; out_at_pulse = '0;
      for (int c = 0; c < 40; c++) begin
         if (p < 0 && cu_sleep_req_o) begin p = c; out_at_pulse = outstanding_o; end
         if (p >= 0 && zero_at < 0 && outstanding_o == 4'd0) zero_at = c;
         if (p >= 0 && fall_at < 0 && !cu_delay_sleep_o) begin
            fall_at = c;
            if (zero_at < 0) early_drop = 1;
         end
         flush_done = (p >= 0 && c == p + 2);
         rsp        = (p >= 0 && (c == p + 3 || c == p + 5 || c == p + 7));
         tick();
      end
      flush_done = 0; rsp = 0;
      n_checks++;
      if (p != 4) $display("FAIL drain_pulse_cycle: got %0d expected 4", p);
      else n_pass++;
      n_checks++;
      if (out_at_pulse !== 4'd3) $display("FAIL drain_outstanding: got %0d expected 3", out_at_pulse);
      else n_pass++;
      n_checks++;
      if (zero_at != p + 8) $display("FAIL drain_zero_cycle: got %0d expected %0d", zero_at, p + 8);
      else n_pass++;
      n_checks++;
      if (fall_at != p + 9 || early_drop != 0)
         $display("FAIL drain_delay_fall: got %0d (early %0d) expected %0d", fall_at, early_drop, p + 9);
      else n_pass++;
   endtask

   task automatic test_counter_edges();
      do_reset();
      warp_active = 4'b0001;
      req = 1; tick(); req = 0;
      n_checks++;
      if (outstanding_o !== 4'd1) $display("FAIL cnt_one: got %0d expected 1", outstanding_o);
      else n_pass++;
      req = 1; rsp = 1; tick(); req = 0; rsp = 0;
      n_checks++;
      if (outstanding_o !== 4'd1 || err_o !== 1'b0)
         $display("FAIL cnt_both: got %0d err %b expected 1 err 0", outstanding_o, err_o);
      else n_pass++;
      rsp = 1; tick();
      n_checks++;
      if (outstanding_o !== 4'd0 || err_o !== 1'b0)
         $display("FAIL cnt_to_zero: got %0d err %b expected 0 err 0", outstanding_o, err_o);
      else n_pass++;
      tick(); rsp = 0;
      n_checks++;
      if (outstanding_o !== 4'd0 || err_o !== 1'b1)
         $display("FAIL cnt_underflow: got %0d err %b expected 0 err 1", outstanding_o, err_o);
      else n_pass++;
      do_reset();
      warp_active = 4'b0001;
      req = 1;
      repeat (15) tick();
      n_checks++;
      if (outstanding_o !== 4'd15 || err_o !== 1'b0)
         $display("FAIL cnt_full: got %0d err %b expected 15 err 0", outstanding_o, err_o);
      else n_pass++;
      tick(); req = 0;
      n_checks++;
      if (outstanding_o !== 4'd15 || err_o !== 1'b1)
         $display("FAIL cnt_overflow: got %0d err %b expected 15 err 1", outstanding_o, err_o);
      else n_pass++;
   endtask

   task automatic test_counter_random();
      int cnt;
      bit merr;
      int preq, prsp;
      cnt = 0; merr = 0;
      do_reset();
      warp_active = 4'b0010;
      for (int c = 0; c < 300; c++) begin
         n_checks++;
         if (outstanding_o !== 4'(cnt) || err_o !== merr)
            $display("FAIL cnt_random cycle %0d: got %0d err %b expected %0d err %b",
                     c, outstanding_o, err_o, cnt, merr);
         else n_pass++;
         preq = (c < 100) ? 70 : (c < 200) ? 25 : 50;
         prsp = 100 - preq;
         req = ($urandom_range(0, 99) < preq);
         rsp = ($urandom_range(0, 99) < prsp);
         if (req && !rsp) begin
            if (cnt == MAX_OUT) merr = 1; else cnt++;
         end else if (rsp && !req) begin
            if (cnt == 0) merr = 1; else cnt--;
         end
         tick();
      end
      req = 0; rsp = 0;
   endtask

   task automatic test_protocol_errors();
      logic [2:0] obs;
      do_reset();
      flush_done = 1; tick(); flush_done = 0;
      obs = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
      n_checks++;
      if (err_o !== 1'b1 || obs !== 3'b000)
         $display("FAIL err_flush_done_arm: got err %b outs %b expected err 1 outs 000", err_o, obs);
      else n_pass++;
      do_reset();
      warp_active = 4'b1000; tick();
      warp_active = '0;
      repeat (4) tick();
      warp_active = 4'b0100; tick(); warp_active = '0;
      obs = {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o};
      n_checks++;
      if (err_o !== 1'b1 || obs !== 3'b011)
         $display("FAIL err_warp_in_flush: got err %b outs %b expected err 1 outs 011", err_o, obs);
      else n_pass++;
      flush_done = 1; tick(); flush_done = 0;
      tick();
      n_checks++;
      if (cu_delay_sleep_o !== 1'b0) $display("FAIL err_then_sleep: got delay %b expected 0", cu_delay_sleep_o);
      else n_pass++;
   endtask

   task automatic test_reset_in_drain();
      int pulses, delays, p;
      do_reset();
      warp_active = 4'b0001; req = 1;
      repeat (2) tick();
      warp_active = '0; req = 0;
      repeat (4) tick();
      flush_done = 1; tick(); flush_done = 0;
      n_checks++;
      if (cu_delay_sleep_o !== 1'b1 || flush_req_o !== 1'b0 || outstanding_o !== 4'd2)
         $display("FAIL pre_reset_drain: got delay %b flush %b out %0d expected 1 0 2",
                  cu_delay_sleep_o, flush_req_o, outstanding_o);
      else n_pass++;
      #2 rst_ni = 0;
      #1;
      n_checks++;
      if ({cu_sleep_req_o, flush_req_o, cu_delay_sleep_o, err_o, outstanding_o} !== 8'h00)
         $display("FAIL async_reset_outputs: got %b expected 00000000",
                  {cu_sleep_req_o, flush_req_o, cu_delay_sleep_o, err_o, outstanding_o});
      else n_pass++;
      tick();
      rst_ni = 1;
      pulses = 0; delays = 0;
      for (int c = 0; c < 10; c++) begin
         if (cu_sleep_req_o) pulses++;
         if (cu_delay_sleep_o) delays++;
         tick();
      end
      n_checks++;
      if (pulses != 0 || delays != 0)
         $display("FAIL rearm_quiet: got %0d pulses %0d delays expected 0 0", pulses, delays);
      else n_pass++;
      warp_active = 4'b0001; tick(); warp_active = '0;
      p = -1;
      for (int c = 0; c < 8; c++) begin
         if (p < 0 && cu_sleep_req_o) p = c;
         tick();
      end
      n_checks++;
      if (p != 4) $display("FAIL rearm_pulse: got cycle %0d expected 4", p);
      else n_pass++;
   endtask

   initial begin
      rst_ni = 0; warp_active = '0; busy = 0; req = 0; rsp = 0; flush_done = 0;
      test_reset();
      test_idle_timing();
      test_idle_restart();
      test_random_patterns();
      test_drain();
      test_counter_edges();
      test_counter_random();
      test_protocol_errors();
      test_reset_in_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
